fp16_div_seq: RTL and testbench

Sequential IEEE-754 half-precision divider computing `a / b` with a radix-2 restoring mantissa recurrence and valid/ready handshakes on both sides. It is the full-division counterpart to the team's combinational fp16 reciprocal. Datapaths that need an exact, correctly-rounded quotient use this block instead of multiplying by an approximate reciprocal. It sits in the fp16 arithmetic library and is instantiated behind the same operand-issue logic as the other multi-cycle fp16 units.

---
 rtl/fp16_div_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fp16_div_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fp16_div_seq.sv
// Sequential fp16 divider: restoring radix-2 mantissa recurrence, round-to-nearest-even,
// subnormals flushed to zero on input and output, valid/ready handshakes on both sides.
module fp16_div_seq #(
   parameter logic [15:0] QNAN = 16'h7E01
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] result,
   output logic        dz,
   output logic        invalid
);

   typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

   state_t             state_reg, state_next;
   logic [11:0]        r_reg, r_next;
   logic [10:0]        d_reg, d_next;
   logic [13:0]        q_reg, q_next;
   logic [3:0]         cnt_reg, cnt_next;
   logic signed [6:0]  e_reg, e_next;
   logic               sign_reg, sign_next;
   logic [15:0]        result_reg, result_next;
   logic               dz_reg, dz_next;
   logic               invalid_reg, invalid_next;

   // Operand classification (exp == 0 counts as zero regardless of mantissa)
   logic [4:0] ea, eb;
   logic [9:0] ma, mb;
   logic       a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sign_in;

   assign ea      = a[14:10];
   assign eb      = b[14:10];
   assign ma      = a[9:0];
   assign mb      = b[9:0];
   assign a_nan   = (&ea) && (|ma);
   assign a_inf   = (&ea) && !(|ma);
   assign a_zero  = !(|ea);
   assign b_nan   = (&eb) && (|mb);
   assign b_inf   = (&eb) && !(|mb);
   assign b_zero  = !(|eb);
   assign sign_in = a[15] ^ b[15];

   logic        spec_hit, spec_dz, spec_inv;
   logic [15:0] spec_res;

   always_comb begin
      spec_hit = 1'b1;
      spec_res = 16'h0000;
      spec_dz  = 1'b0;
      spec_inv = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
         spec_res = QNAN;
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_res = {sign_in, 5'h1F, 10'h000};
      end else if (b_inf) begin
         spec_res = {sign_in, 15'h0000};
      end else if (b_zero) begin
         spec_res = {sign_in, 5'h1F, 10'h000};
         spec_dz  = 1'b1;
      end else if (a_zero) begin
         spec_res = {sign_in, 15'h0000};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // One restoring step; r < 2d holds throughout, so the shifted remainder fits 12 bits
   logic        qbit;
   logic [11:0] r_sub, r_shift;

   assign qbit    = (r_reg >= {1'b0, d_reg});
   assign r_sub   = qbit ? (r_reg - {1'b0, d_reg}) : r_reg;
   assign r_shift = r_sub << 1;

   // Normalise, round to nearest even, then saturate/flush
   logic [9:0]        n_mant;
   logic              n_guard, n_sticky, n_inc;
   logic [10:0]       n_rnd;
   logic signed [8:0] n_exp;
   logic [15:0]       norm_res;

   always_comb begin
      n_sticky = |r_reg;
      if (q_reg[13]) begin
         n_mant   = q_reg[12:3];
         n_guard  = q_reg[2];
         n_sticky = n_sticky | q_reg[1] | q_reg[0];
         n_exp    = {{2{e_reg[6]}}, e_reg} + 9'sd15;
      end else begin
         n_mant   = q_reg[11:2];
         n_guard  = q_reg[1];
         n_sticky = n_sticky | q_reg[0];
         n_exp    = {{2{e_reg[6]}}, e_reg} + 9'sd14;
      end
      n_inc = n_guard && (n_sticky || n_mant[0]);
      n_rnd = {1'b0, n_mant} + {10'b0, n_inc};
      if (n_rnd[10]) begin
         n_exp = n_exp + 9'sd1;
      end
      if (n_exp >= 9'sd31) begin
         norm_res = {sign_reg, 5'h1F, 10'h000};
      end else if (n_exp <= 9'sd0) begin
         norm_res = {sign_reg, 15'h0000};
      end else begin
         norm_res = {sign_reg, n_exp[4:0], n_rnd[9:0]};
      end
   end

   always_comb begin
      state_next   = state_reg;
      r_next       = r_reg;
      d_next       = d_reg;
      q_next       = q_reg;
      cnt_next     = cnt_reg;
      e_next       = e_reg;
      sign_next    = sign_reg;
      result_next  = result_reg;
      dz_next      = dz_reg;
      invalid_next = invalid_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               sign_next = sign_in;
               if (spec_hit) begin
                  result_next  = spec_res;
                  dz_next      = spec_dz;
                  invalid_next = spec_inv;
                  state_next   = DONE;
               end else begin
                  r_next     = {2'b01, ma};
                  d_next     = {1'b1, mb};
                  e_next     = {2'b00, ea} - {2'b00, eb};
                  q_next     = 14'h0000;
                  cnt_next   = 4'd13;
                  state_next = DIV;
               end
            end
         end
         DIV: begin
            r_next   = r_shift;
            q_next   = {q_reg[12:0], qbit};
            cnt_next = cnt_reg - 4'd1;
            if (cnt_reg == 4'd0) begin
               state_next = NORM;
            end
         end
         NORM: begin
            result_next  = norm_res;
            dz_next      = 1'b0;
            invalid_next = 1'b0;
            state_next   = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         r_reg       <= 12'h000;
         d_reg       <= 11'h000;
         q_reg       <= 14'h0000;
         cnt_reg     <= 4'd0;
         e_reg       <= 7'sd0;
         sign_reg    <= 1'b0;
         result_reg  <= 16'h0000;
         dz_reg      <= 1'b0;
         invalid_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         r_reg       <= r_next;
         d_reg       <= d_next;
         q_reg       <= q_next;
         cnt_reg     <= cnt_next;
         e_reg       <= e_next;
         sign_reg    <= sign_next;
         result_reg  <= result_next;
         dz_reg      <= dz_next;
         invalid_reg <= invalid_next;
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign result    = result_reg;
   assign dz        = dz_reg;
   assign invalid   = invalid_reg;

endmodule

// File: tb/tb_fp16_div_seq.sv
// Self-checking bench for fp16_div_seq: exact-division reference model, per-cycle output
// compare against a scoreboard queue, directed test-plan vectors, randomized operands.
module tb_fp16_div_seq;

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, dz, invalid;
   logic [15:0] a, b, result;

   int errors = 0;
   int checks = 0;
   logic [17:0] exp_q[$];   // {invalid, dz, result}

   always #5 clk = ~clk;

   fp16_div_seq #(.QNAN(16'h7E01)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .dz(dz), .invalid(invalid)
   );

   task automatic check(input string name, input logic [17:0] act, input logic [17:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Reference: exact integer quotient of the significands, correctly rounded
   function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y);
      int ex, ey, mx, my, e, sh;
      logic s;
      longint num, den, qq, rem, m11;
      bit xn, xi, xz, yn, yi, yz, g, st;
      ex = int'(x[14:10]); mx = int'(x[9:0]);
      ey = int'(y[14:10]); my = int'(y[9:0]);
      s  = x[15] ^ y[15];
      xn = (ex == 31) && (mx != 0); xi = (ex == 31) && (mx == 0); xz = (ex == 0);
      yn = (ey == 31) && (my != 0); yi = (ey == 31) && (my == 0); yz = (ey == 0);
      if (xn || yn || (xi && yi) || (xz && yz)) return {2'b10, 16'h7E01};
      if (xi) return {2'b00, s, 15'h7C00};
      if (yi) return {2'b00, s, 15'h0000};
      if (yz) return {2'b01, s, 15'h7C00};
      if (xz) return {2'b00, s, 15'h0000};
      num = longint'(1024 + mx) << 30;
      den = longint'(1024 + my);
      qq  = num / den;
      rem = num % den;
      if (qq >= (longint'(1) << 30)) begin sh = 20; e = ex - ey + 15; end
      else begin sh = 19; e = ex - ey + 14; end
      m11 = qq >> sh;
      g   = qq[sh-1];
      st  = (rem != 0) || ((qq & ((longint'(1) << (sh - 1)) - 1)) != 0);
      if (g && (st || m11[0])) m11 = m11 + 1;
      if (m11 == 2048) begin m11 = 1024; e = e + 1; end
      if (e >= 31) return {2'b00, s, 15'h7C00};
      if (e <= 0)  return {2'b00, s, 15'h0000};
      return {2'b00, s, 5'(e), 10'(m11 - 1024)};
   endfunction

   function automatic bit is_special(input logic [15:0] x, input logic [15:0] y);
      return (x[14:10] == 5'h1F) || (x[14:10] == 5'h00) ||
             (y[14:10] == 5'h1F) || (y[14:10] == 5'h00);
   endfunction

   // Compare process: every cycle a result is presented it must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got result %h with no operation pending", result);
         end else begin
            check("result",  18'(result),  18'(exp_q[0][15:0]));
            check("dz",      18'(dz),      18'(exp_q[0][16]));
            check("invalid", 18'(invalid), 18'(exp_q[0][17]));
         end
      end
   end

   always @(posedge clk) begin
      if (!rst && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
   end

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input int hold);
      int n;
      logic [17:0] e;
      n = 0;
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      check("in_ready_before_issue", 18'(in_ready), 18'(1));
      e = model(ta, tb_v);
      a = ta; b = tb_v; in_valid = 1'b1;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom);
      n = 1;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      check("latency", 18'(n), is_special(ta, tb_v) ? 18'(1) : 18'(16));
      $display("op %h / %h -> %h dz=%0b inv=%0b (model %h dz=%0b inv=%0b) hold=%0d",
               ta, tb_v, result, dz, invalid, e[15:0], e[16], e[17], hold);
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'($urandom_range(0, 1));
         a = 16'($urandom); b = 16'($urandom);
         @(negedge clk);
         check("in_ready_while_held", 18'(in_ready), 18'(0));
         check("out_valid_while_held", 18'(out_valid), 18'(1));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("in_ready_after_handshake", 18'(in_ready), 18'(1));
      check("out_valid_after_handshake", 18'(out_valid), 18'(0));
   endtask

   logic [15:0] dir_a [11] = '{16'h3C00, 16'h3C00, 16'h4600, 16'h3C00, 16'h3C00, 16'h8000,
                               16'h7C00, 16'h7E00, 16'h0001, 16'h7BFF, 16'h0400};
   logic [15:0] dir_b [11] = '{16'h4000, 16'h4200, 16'h4200, 16'h3E00, 16'h0000, 16'h8000,
                               16'hC000, 16'h3C00, 16'h3C00, 16'h0400, 16'h7BFF};
   logic [17:0] dir_x [11] = '{18'h03800, 18'h03555, 18'h04000, 18'h03955, 18'h17C00, 18'h27E01,
                               18'h0FC00, 18'h27E01, 18'h00000, 18'h07C00, 18'h00000};

   initial begin
      logic [15:0] ra, rb;
      int sel;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0;
      repeat (3) @(negedge clk);
      check("reset_out_valid", 18'(out_valid), 18'(0));
      check("reset_result",    18'(result),    18'(0));
      check("reset_flags",     18'({dz, invalid}), 18'(0));
      rst = 1'b0;
      @(negedge clk);
      check("in_ready_after_reset", 18'(in_ready), 18'(1));

      for (int i = 0; i < 11; i++) begin
         check("model_pin", model(dir_a[i], dir_b[i]), dir_x[i]);
         run_op(dir_a[i], dir_b[i], (i == 0) ? 10 : 0);
      end

      // Reset in the middle of the recurrence discards the operation
      a = 16'h3C00; b = 16'h4200; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("midrun_reset_out_valid", 18'(out_valid), 18'(0));
      check("midrun_reset_result",    18'(result),    18'(0));
      check("midrun_reset_flags",     18'({dz, invalid}), 18'(0));
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("in_ready_after_midrun_reset", 18'(in_ready), 18'(1));
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("no_output_after_reset", 18'(out_valid), 18'(0));
      end
      run_op(16'h4600, 16'h4200, 1);

      for (int i = 0; i < 150; i++) begin
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         sel = int'($urandom_range(0, 9));
         if (sel == 0) ra[14:10] = 5'h00;
         if (sel == 1) rb[14:10] = 5'h1F;
         if (sel == 2) rb[14:10] = 5'h00;
         if (sel == 3) ra[14:10] = 5'h1F;
         run_op(ra, rb, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
